// File: rtl/sys_defs.sv
// Shared processor definitions: data width, CDB packet, ROB entry and tag types.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package sys_defs;

    localparam int XLEN      = 32;
    localparam int ROB_DEPTH = 8;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    // Architectural x0; writes to it are dropped at retirement.
    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef logic [ROB_TAG_W-1:0] ROB_TAG;

    // Completion broadcast from the functional units.
    typedef struct packed {
        ROB_TAG            Tag;
        logic [XLEN-1:0]   Value;
        logic [XLEN-1:0]   NPC;
        logic              take_branch;
        logic              valid;
    } CDB_PACKET;

    // One reorder buffer slot.
    typedef struct packed {
        logic              valid;
        logic              complete;
        logic [4:0]        dest;
        logic [XLEN-1:0]   NPC;
        logic [XLEN-1:0]   Value;
        logic              take_branch;
        logic              halt;
    } ROB_ENTRY;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping circular-buffer pointer with increment and clear.
// Latency: pointer updates at the rising edge after inc/clr.
// Backpressure: none; the caller only raises inc when the move is legal.
module rob_ptr #(
    parameter int DEPTH = 8,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    // Clear (reset or flush) dominates; otherwise step forward, rolling DEPTH-1 -> 0.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == W'(DEPTH - 1)) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate per dispatch, capture CDB results, retire in program order.
// Latency: CDB->retire one cycle later, or same cycle for the head when ROB_BYPASS_EN is defined.
// Backpressure: dispatch_ready drops when full or halted; a retiring taken branch flushes everything.
module reorder_buffer #(
    parameter int ROB_DEPTH = sys_defs::ROB_DEPTH,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dispatch_valid,
    input  logic [4:0]               dispatch_dest_reg_idx,
    input  logic [sys_defs::XLEN-1:0] dispatch_NPC,
    input  logic                     dispatch_halt,
    output logic                     dispatch_ready,
    output logic [TAG_W-1:0]         dispatch_tag,
    input  sys_defs::CDB_PACKET      cdb_packet,
    output logic                     retire_en,
    output logic [TAG_W-1:0]         retire_tag,
    output logic                     wb_regfile_en,
    output logic [4:0]               wb_regfile_idx,
    output logic [sys_defs::XLEN-1:0] wb_regfile_data,
    output logic                     flush,
    output logic [sys_defs::XLEN-1:0] flush_NPC,
    output logic                     halted
);

    import sys_defs::*;

    ROB_ENTRY          entries [ROB_DEPTH];
    ROB_ENTRY          head_entry;
    ROB_ENTRY          new_entry;
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;
    logic              halted_q;
    logic [TAG_W-1:0]  cdb_tag;
    logic              cdb_write;
    logic              cdb_hit_head;
    logic              head_complete;
    logic [XLEN-1:0]   head_value;
    logic [XLEN-1:0]   head_npc;
    logic              head_take_branch;
    logic              dispatch_fire;

    assign cdb_tag    = cdb_packet.Tag;
    assign head_entry = entries[head];

    // A broadcast only lands on a live entry; stale tags are dropped.
    assign cdb_write = cdb_packet.valid && entries[cdb_tag].valid;

    // Head completion view; with bypass a same-cycle CDB hit on head is forwarded.
    always_comb begin
        cdb_hit_head = 1'b0;
`ifdef ROB_BYPASS_EN
        cdb_hit_head = cdb_packet.valid && (cdb_tag == head);
`endif
        head_complete    = head_entry.complete || cdb_hit_head;
        head_value       = cdb_hit_head ? cdb_packet.Value       : head_entry.Value;
        head_npc         = cdb_hit_head ? cdb_packet.NPC         : head_entry.NPC;
        head_take_branch = cdb_hit_head ? cdb_packet.take_branch : head_entry.take_branch;
    end

    // Retire, flush and dispatch handshake; all gated by the sticky halt.
    always_comb begin
        retire_en      = head_entry.valid && head_complete && !halted_q;
        flush          = retire_en && head_take_branch;
        dispatch_ready = (count != (TAG_W + 1)'(ROB_DEPTH)) && !halted_q;
        dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
        dispatch_tag   = tail;
        retire_tag     = retire_en ? head : '0;
        wb_regfile_en  = retire_en && (head_entry.dest != ZERO_REG);
        wb_regfile_idx = retire_en ? head_entry.dest : '0;
        wb_regfile_data = retire_en ? head_value : '0;
        flush_NPC      = flush ? head_npc : '0;
        halted         = halted_q;
    end

    // Fresh entry written at tail on an accepted dispatch.
    always_comb begin
        new_entry             = '0;
        new_entry.valid       = 1'b1;
        new_entry.complete    = 1'b0;
        new_entry.dest        = dispatch_dest_reg_idx;
        new_entry.NPC         = dispatch_NPC;
        new_entry.halt        = dispatch_halt;
    end

    rob_ptr #(.DEPTH(ROB_DEPTH), .W(TAG_W)) u_head_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (retire_en),
        .clr   (flush),
        .ptr   (head)
    );

    rob_ptr #(.DEPTH(ROB_DEPTH), .W(TAG_W)) u_tail_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (dispatch_fire),
        .clr   (flush),
        .ptr   (tail)
    );

    // Entry storage: flush wipes everything; else CDB capture, then retire clear, then allocate.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (cdb_write) begin
                entries[cdb_tag].complete    <= 1'b1;
                entries[cdb_tag].Value       <= cdb_packet.Value;
                entries[cdb_tag].NPC         <= cdb_packet.NPC;
                entries[cdb_tag].take_branch <= cdb_packet.take_branch;
            end
            if (retire_en) begin
                entries[head] <= '0;
            end
            // Tail never aliases a live head here: dispatch is refused while full.
            if (dispatch_fire) begin
                entries[tail] <= new_entry;
            end
        end
    end

    // Occupancy count and sticky halt flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (flush) begin
                count <= '0;
            end else begin
                case ({dispatch_fire, retire_en})
                    2'b10:   count <= count + (TAG_W + 1)'(1);
                    2'b01:   count <= count - (TAG_W + 1)'(1);
                    default: count <= count;
                endcase
            end
            if (retire_en && head_entry.halt) begin
                halted_q <= 1'b1;
            end
        end
    end

endmodule
